// File: rtl/aes_mode_ctrl.sv
// aes_mode_ctrl: ECB/CBC/CTR chaining controller wrapped around a start/finish AES128 core.
// Optional CTR mode is compiled in when AES_MODE_CTR_EN is defined.
module aes_mode_ctrl #(
   parameter int BLK_W       = 128,
   parameter int CTR_W       = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_load,
   input  logic [1:0]       cfg_mode,
   input  logic             cfg_cipher,
   input  logic [BLK_W-1:0] cfg_key,
   input  logic [BLK_W-1:0] cfg_iv,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [BLK_W-1:0] s_data,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [BLK_W-1:0] m_data,
   output logic             m_last,
   output logic             core_start,
   output logic [BLK_W-1:0] core_din,
   output logic [BLK_W-1:0] core_key,
   output logic             core_cipher,
   input  logic [BLK_W-1:0] core_dout,
   input  logic             core_finish,
   output logic             busy,
   output logic             err
);

   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [1:0] MODE_ECB = 2'b00;
   localparam logic [1:0] MODE_CBC = 2'b01;
`ifdef AES_MODE_CTR_EN
   localparam logic [1:0] MODE_CTR = 2'b10;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_OUT   = 2'b11
   } state_t;

   if (CTR_W < 1 || CTR_W > BLK_W) begin : g_bad_ctr_w
      $error("aes_mode_ctrl: CTR_W must lie in 1..BLK_W");
   end

   state_t             state_q, state_d;
   logic [1:0]         mode_q, mode_d;
   logic               cipher_q, cipher_d;
   logic [BLK_W-1:0]   key_q, key_d;
   logic [BLK_W-1:0]   iv_q, iv_d;
   logic [BLK_W-1:0]   chain_q, chain_d;
   logic [BLK_W-1:0]   blk_q, blk_d;
   logic               last_q, last_d;
   logic [BLK_W-1:0]   mdata_q, mdata_d;
   logic               mlast_q, mlast_d;
   logic               cfg_ok_q, cfg_ok_d;
   logic               err_q, err_d;
   logic [TMR_W-1:0]   timer_q, timer_d;

   logic               cfg_mode_ok;
   logic [BLK_W-1:0]   din_c;
   logic               cipher_c;
   logic [BLK_W-1:0]   result_c;
   logic [BLK_W-1:0]   chain_upd_c;

`ifdef AES_MODE_CTR_EN
   logic [BLK_W-1:0]   ctr_inc_c;
   assign cfg_mode_ok = (cfg_mode != 2'b11);
   always_comb begin
      ctr_inc_c = chain_q;
      ctr_inc_c[CTR_W-1:0] = chain_q[CTR_W-1:0] + 1'b1;
   end
`else
   assign cfg_mode_ok = (cfg_mode == MODE_ECB) || (cfg_mode == MODE_CBC);
`endif

   // Core inputs come only from registers held across ISSUE/WAIT, so they stay stable for the core.
   always_comb begin
      din_c       = blk_q;
      cipher_c    = cipher_q;
      result_c    = core_dout;
      chain_upd_c = chain_q;
      case (mode_q)
         MODE_CBC: begin
            if (cipher_q) begin
               din_c       = blk_q ^ chain_q;
               chain_upd_c = core_dout;
            end else begin
               result_c    = core_dout ^ chain_q;
               chain_upd_c = blk_q;
            end
         end
`ifdef AES_MODE_CTR_EN
         MODE_CTR: begin
            din_c       = chain_q;
            cipher_c    = 1'b1;
            result_c    = core_dout ^ blk_q;
            chain_upd_c = ctr_inc_c;
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      cipher_d = cipher_q;
      key_d    = key_q;
      iv_d     = iv_q;
      chain_d  = chain_q;
      blk_d    = blk_q;
      last_d   = last_q;
      mdata_d  = mdata_q;
      mlast_d  = mlast_q;
      cfg_ok_d = cfg_ok_q;
      err_d    = err_q;
      timer_d  = timer_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_load) begin
               mode_d   = cfg_mode;
               cipher_d = cfg_cipher;
               key_d    = cfg_key;
               iv_d     = cfg_iv;
               chain_d  = cfg_iv;
               cfg_ok_d = cfg_mode_ok;
               err_d    = !cfg_mode_ok;
            end else if (s_valid && cfg_ok_q) begin
               blk_d   = s_data;
               last_d  = s_last;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            timer_d = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (core_finish) begin
               mdata_d = result_c;
               mlast_d = last_q;
               chain_d = last_q ? iv_q : chain_upd_c;
               state_d = ST_OUT;
            end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_OUT: begin
            if (m_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (cfg_load && state_q != ST_IDLE) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         mode_q   <= '0;
         cipher_q <= 1'b0;
         key_q    <= '0;
         iv_q     <= '0;
         chain_q  <= '0;
         blk_q    <= '0;
         last_q   <= 1'b0;
         mdata_q  <= '0;
         mlast_q  <= 1'b0;
         cfg_ok_q <= 1'b0;
         err_q    <= 1'b0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         cipher_q <= cipher_d;
         key_q    <= key_d;
         iv_q     <= iv_d;
         chain_q  <= chain_d;
         blk_q    <= blk_d;
         last_q   <= last_d;
         mdata_q  <= mdata_d;
         mlast_q  <= mlast_d;
         cfg_ok_q <= cfg_ok_d;
         err_q    <= err_d;
         timer_q  <= timer_d;
      end
   end

   assign s_ready     = (state_q == ST_IDLE) && cfg_ok_q && !cfg_load;
   assign m_valid     = (state_q == ST_OUT);
   assign m_data      = mdata_q;
   assign m_last      = mlast_q;
   assign core_start  = (state_q == ST_ISSUE);
   assign core_din    = din_c;
   assign core_key    = key_q;
   assign core_cipher = cipher_c;
   assign busy        = (state_q != ST_IDLE);
   assign err         = err_q;

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// tb_aes_mode_ctrl: randomized scoreboard bench for aes_mode_ctrl with a stand-in invertible block core.
// Define AES_MODE_CTR_EN for both files to exercise CTR mode.
module tb_aes_mode_ctrl;
   localparam int BW = 128;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_load, cfg_cipher;
   logic [1:0]    cfg_mode;
   logic [BW-1:0] cfg_key, cfg_iv;
   logic          s_valid, s_ready, s_last;
   logic [BW-1:0] s_data;
   logic          m_valid, m_ready, m_last;
   logic [BW-1:0] m_data;
   logic          core_start, core_cipher, core_finish;
   logic [BW-1:0] core_din, core_key, core_dout;
   logic          busy, err;

   always #5 clk = ~clk;

   aes_mode_ctrl #(.BLK_W(BW), .CTR_W(32), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_cipher(cfg_cipher),
      .cfg_key(cfg_key), .cfg_iv(cfg_iv),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .core_start(core_start), .core_din(core_din), .core_key(core_key),
      .core_cipher(core_cipher), .core_dout(core_dout), .core_finish(core_finish),
      .busy(busy), .err(err)
   );

   typedef struct { logic [BW-1:0] data; logic last; } out_t;
   typedef struct { logic [BW-1:0] din; logic cip; } din_t;

   out_t          exp_out_q[$];
   din_t          exp_din_q[$];
   logic [BW-1:0] rx_log[$];
   int            n_vec = 0;
   int            n_bad = 0;
   bit            hang = 0;
   bit            bp_hold = 0;

   // Reference state: what the controller should hold, in chaining-mode terms.
   logic [1:0]    mode_m = 2'b00;
   logic          cip_m = 1'b0;
   logic [BW-1:0] key_m = '0, iv_m = '0, chain_m = '0;

   // Stand-in cipher: keyed rotation, exactly invertible so CBC decrypt can be checked end to end.
   function automatic logic [BW-1:0] core_f(input logic [BW-1:0] x, input logic [BW-1:0] k, input logic enc);
      logic [BW-1:0] t;
      if (enc) begin
         core_f = {x[114:0], x[127:115]} ^ k;
      end else begin
         t = x ^ k;
         core_f = {t[12:0], t[127:13]};
      end
   endfunction

   function automatic bit mode_ok(input logic [1:0] m);
`ifdef AES_MODE_CTR_EN
      return m != 2'b11;
`else
      return m == 2'b00 || m == 2'b01;
`endif
   endfunction

   function automatic logic [BW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s: bound expired before the expected event", name);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Core responder: checks every start against the model, answers after a random delay,
   // and throws stray finish pulses while the controller is idle.
   initial begin
      bit            pend = 0, fin = 0;
      int            cnt = 0;
      logic [BW-1:0] res = '0;
      din_t          e;
      core_finish = 1'b0;
      core_dout   = '0;
      forever begin
         @(negedge clk);
         if (fin) begin
            core_finish = 1'b0;
            core_dout   = rnd128();
            fin = 0;
         end
         if (!rst) begin
            pend = 0;
         end else if (core_start) begin
            if (exp_din_q.size() == 0) begin
               fail("core_start_unexpected");
            end else begin
               e = exp_din_q.pop_front();
               chk("core_din", core_din, e.din);
               chk("core_cipher", BW'(core_cipher), BW'(e.cip));
               chk("core_key", core_key, key_m);
            end
            if (!hang) begin
               pend = 1;
               cnt  = $urandom_range(0, 6);
               res  = core_f(core_din, core_key, core_cipher);
            end
         end else if (pend) begin
            if (cnt == 0) begin
               core_finish = 1'b1;
               core_dout   = res;
               fin  = 1;
               pend = 0;
            end else begin
               cnt--;
            end
         end else if (!busy && !fin && $urandom_range(0, 7) == 0) begin
            core_finish = 1'b1;
            core_dout   = rnd128();
            fin = 1;
         end
      end
   end

   // Output monitor: random m_ready, holds stability while stalled, pops the scoreboard on transfer.
   initial begin
      bit            hold = 0;
      logic [BW-1:0] prev_d = '0;
      logic          prev_l = 1'b0;
      out_t          e;
      m_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (hold) begin
            chk("m_valid_held", BW'(m_valid), BW'(1'b1));
            chk("m_data_stable", m_data, prev_d);
            chk("m_last_stable", BW'(m_last), BW'(prev_l));
         end
         m_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
         if (m_valid && m_ready) begin
            if (exp_out_q.size() == 0) begin
               fail("m_valid_unexpected");
            end else begin
               e = exp_out_q.pop_front();
               chk("m_data", m_data, e.data);
               chk("m_last", BW'(m_last), BW'(e.last));
               $display("xfer: m_data=%h m_last=%0d", m_data, m_last);
            end
            rx_log.push_back(m_data);
         end
         hold   = m_valid && !m_ready;
         prev_d = m_data;
         prev_l = m_last;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (busy) fail("wait_idle");
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_out_q.size() != 0 || busy) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (exp_out_q.size() != 0 || busy) fail("wait_drain");
   endtask

   task automatic do_cfg(input logic [1:0] m, input logic c, input logic [BW-1:0] k, input logic [BW-1:0] v);
      wait_idle();
      @(negedge clk);
      cfg_mode = m; cfg_cipher = c; cfg_key = k; cfg_iv = v; cfg_load = 1'b1;
      @(negedge clk);
      cfg_load = 1'b0;
      #1;
      mode_m = m; cip_m = c; key_m = k; iv_m = v; chain_m = v;
      chk("cfg_err", BW'(err), BW'(!mode_ok(m)));
      chk("cfg_s_ready", BW'(s_ready), BW'(mode_ok(m)));
      $display("cfg: mode=%0d cipher=%0d err=%0d", m, c, err);
   endtask

   task automatic send_block(input logic [BW-1:0] blk, input logic last);
      int            n = 0;
      logic [BW-1:0] din, outv, nchain;
      logic          cip;
      @(negedge clk);
      s_data = blk; s_last = last; s_valid = 1'b1;
      #1;
      while (!s_ready && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!s_ready) begin
         fail("s_ready_wait");
         s_valid = 1'b0;
      end else begin
         case (mode_m)
            2'b00: begin
               din = blk; cip = cip_m;
               outv = core_f(blk, key_m, cip_m);
               nchain = chain_m;
            end
            2'b01: begin
               cip = cip_m;
               if (cip_m) begin
                  din = blk ^ chain_m;
                  outv = core_f(din, key_m, 1'b1);
                  nchain = outv;
               end else begin
                  din = blk;
                  outv = core_f(blk, key_m, 1'b0) ^ chain_m;
                  nchain = blk;
               end
            end
            default: begin
               din = chain_m; cip = 1'b1;
               outv = core_f(chain_m, key_m, 1'b1) ^ blk;
               nchain = chain_m;
               nchain[31:0] = chain_m[31:0] + 32'd1;
            end
         endcase
         if (last) nchain = iv_m;
         exp_din_q.push_back('{din: din, cip: cip});
         if (!hang) begin
            exp_out_q.push_back('{data: outv, last: last});
            chain_m = nchain;
         end
         $display("send: blk=%h last=%0d exp_din=%h", blk, last, din);
         @(negedge clk);
         s_valid = 1'b0; s_data = rnd128(); s_last = $urandom_range(0, 1);
      end
   endtask

   initial begin
      logic [BW-1:0] k, v, p, d;
      logic [BW-1:0] pts[3];
      logic [BW-1:0] cts[3];
      int            base, n;
      logic [1:0]    m;

      rst = 1'b0;
      cfg_load = 1'b0; cfg_mode = 2'b00; cfg_cipher = 1'b0; cfg_key = '0; cfg_iv = '0;
      s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_s_ready", BW'(s_ready), '0);
      chk("rst_m_valid", BW'(m_valid), '0);
      chk("rst_m_data", m_data, '0);
      chk("rst_m_last", BW'(m_last), '0);
      chk("rst_core_start", BW'(core_start), '0);
      chk("rst_core_din", core_din, '0);
      chk("rst_core_key", core_key, '0);
      chk("rst_core_cipher", BW'(core_cipher), '0);
      chk("rst_busy", BW'(busy), '0);
      chk("rst_err", BW'(err), '0);
      rst = 1'b1;

      // No configuration yet: a presented block must not be taken.
      s_valid = 1'b1; s_data = rnd128();
      repeat (3) begin
         @(negedge clk);
         chk("nocfg_busy", BW'(busy), '0);
      end
      s_valid = 1'b0;

      do_cfg(2'b00, 1'b1, rnd128(), rnd128());
      for (int i = 0; i < 4; i++) send_block(rnd128(), $urandom_range(0, 1));
      do_cfg(2'b00, 1'b0, rnd128(), rnd128());
      for (int i = 0; i < 3; i++) send_block(rnd128(), $urandom_range(0, 1));

      // Chain reload after a last block: the same plaintext twice gives the same ciphertext.
      do_cfg(2'b01, 1'b1, rnd128(), rnd128());
      wait_drain();
      base = rx_log.size();
      p = rnd128();
      send_block(p, 1'b1);
      send_block(p, 1'b0);
      send_block(rnd128(), 1'b0);
      wait_drain();
      if (rx_log.size() >= base + 2) chk("cbc_last_reload", rx_log[base+1], rx_log[base]);
      else fail("cbc_last_reload_rx");

      // CBC round trip through the controller in both directions.
      k = rnd128(); v = rnd128();
      do_cfg(2'b01, 1'b1, k, v);
      base = rx_log.size();
      for (int i = 0; i < 3; i++) begin
         pts[i] = rnd128();
         send_block(pts[i], i == 2);
      end
      wait_drain();
      for (int i = 0; i < 3; i++) cts[i] = (rx_log.size() > base + i) ? rx_log[base+i] : '0;
      do_cfg(2'b01, 1'b0, k, v);
      base = rx_log.size();
      for (int i = 0; i < 3; i++) send_block(cts[i], i == 2);
      wait_drain();
      for (int i = 0; i < 3; i++) begin
         if (rx_log.size() > base + i) chk("cbc_roundtrip", rx_log[base+i], pts[i]);
         else fail("cbc_roundtrip_rx");
      end

      // Configuration attempt while a block is in flight is refused and flagged.
      send_block(rnd128(), 1'b0);
      cfg_mode = 2'b00; cfg_cipher = ~cip_m; cfg_key = rnd128(); cfg_iv = rnd128(); cfg_load = 1'b1;
      @(negedge clk);
      cfg_load = 1'b0;
      #1;
      chk("busy_cfg_err", BW'(err), BW'(1'b1));
      wait_drain();
      chk("busy_cfg_err_sticky", BW'(err), BW'(1'b1));
      do_cfg(2'b01, 1'b1, rnd128(), rnd128());

      // Backpressure: output held steady and input closed until m_ready.
      bp_hold = 1;
      send_block(rnd128(), 1'b1);
      n = 0;
      while (!m_valid && n < 100) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (!m_valid) fail("bp_m_valid");
      d = m_data;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #2;
         chk("bp_m_valid", BW'(m_valid), BW'(1'b1));
         chk("bp_m_data", m_data, d);
         chk("bp_s_ready", BW'(s_ready), '0);
      end
      bp_hold = 0;
      n = 0;
      while (!(m_valid && m_ready) && n < 100) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (!(m_valid && m_ready)) fail("bp_release");
      @(negedge clk);
      #2;
      chk("bp_idle_busy", BW'(busy), '0);
      chk("bp_idle_s_ready", BW'(s_ready), BW'(1'b1));

      // Watchdog on a core that never finishes.
      do_cfg(2'b00, 1'b1, rnd128(), rnd128());
      hang = 1;
      send_block(rnd128(), 1'b0);
      n = 0;
      while (busy && n < TO + 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      $display("timeout: busy dropped after %0d cycles err=%0d", n, err);
      chk("timeout_busy", BW'(busy), '0);
      chk("timeout_err", BW'(err), BW'(1'b1));
      chk("timeout_cycles", BW'(n >= TO && n <= TO + 2), BW'(1'b1));
      hang = 0;
      do_cfg(2'b00, 1'b1, rnd128(), rnd128());

      // Reserved and (when compiled out) CTR configurations.
      do_cfg(2'b11, 1'b1, rnd128(), rnd128());
`ifdef AES_MODE_CTR_EN
      v = rnd128();
      v[31:0] = 32'hffff_ffff;
      do_cfg(2'b10, 1'b0, rnd128(), v);
      for (int i = 0; i < 3; i++) send_block(rnd128(), 1'b0);
      send_block(rnd128(), 1'b1);
      send_block(rnd128(), 1'b0);
      wait_drain();
`else
      do_cfg(2'b10, 1'b1, rnd128(), rnd128());
      s_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         #1;
         chk("ctr_off_s_ready", BW'(s_ready), '0);
         chk("ctr_off_busy", BW'(busy), '0);
      end
      s_valid = 1'b0;
`endif

      for (int it = 0; it < 20; it++) begin
`ifdef AES_MODE_CTR_EN
         m = 2'($urandom_range(0, 2));
`else
         m = 2'($urandom_range(0, 1));
`endif
         do_cfg(m, 1'($urandom_range(0, 1)), rnd128(), rnd128());
         for (int b = 0; b < int'($urandom_range(1, 4)); b++) send_block(rnd128(), $urandom_range(0, 3) == 0);
      end

      wait_drain();
      chk("final_out_queue", BW'(exp_out_q.size()), '0);
      chk("final_din_queue", BW'(exp_din_q.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
